button_debounce: RTL and testbench

- Cleans the raw active-low board button so the design never sees a bouncing signal. The raw pin is `BTN_N` on the iCEBreaker.
- Flow: synchronize the pin into the PLL clock domain, then debounce it with a four-state FSM.
- Outputs: a stable pressed level, one-cycle press and release pulses, and an optional one-cycle long-press pulse.
- Placement: directly upstream of the blinky core inside the `icebreaker` top, clocked by the 20 MHz PLL output.

---
 rtl/button_debounce.sv | 132 +++++++++++++
 tb/tb_button_debounce.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Button debouncer: two-flop synchronizer into clk_i, then a four-state debounce FSM.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the hold counter behind long_press_o.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned LONG_CYCLES     = 20000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPending,
        StPressed,
        StReleasePending
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            s1_q;
    logic            s2_q;
    logic            press_done;
    logic            release_done;

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES >= 1");
    end

    // Both stages reset to the released level so reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= btn_ni;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        press_done   = (state_q == StPressPending) && !s2_q && (cnt_q == CntLast);
        release_done = (state_q == StReleasePending) && s2_q && (cnt_q == CntLast);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StReleased;
            cnt_q     <= '0;
            pressed_o <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= press_done;
            release_o <= release_done;
            unique case (state_q)
                StReleased: begin
                    if (!s2_q) begin
                        state_q <= StPressPending;
                        cnt_q   <= CntOne;
                    end
                end
                StPressPending: begin
                    if (s2_q) begin
                        state_q <= StReleased;
                        cnt_q   <= '0;
                    end else if (press_done) begin
                        state_q   <= StPressed;
                        cnt_q     <= '0;
                        pressed_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StPressed: begin
                    if (s2_q) begin
                        state_q <= StReleasePending;
                        cnt_q   <= CntOne;
                    end
                end
                StReleasePending: begin
                    if (!s2_q) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (release_done) begin
                        state_q   <= StReleased;
                        cnt_q     <= '0;
                        pressed_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned      HoldW    = $clog2(LONG_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

    logic [HoldW-1:0] hold_q;

    // hold only clears when a press is accepted, so saturation blocks a second pulse
    // even if the release debounce bounces back to the held state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q       <= '0;
            long_press_o <= 1'b0;
        end else begin
            long_press_o <= pressed_o && (hold_q == HoldLast) && !release_done;
            if (press_done) begin
                hold_q <= '0;
            end else if (pressed_o && (hold_q != HoldMax)) begin
                hold_q <= hold_q + HoldOne;
            end
        end
    end
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboarded bench for button_debounce: a cycle-level behavioural model pushes the
// expected outputs every edge, a monitor compares them; directed checks pin the latencies.
`timescale 1ns/1ps
module tb_button_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned L = 16;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic pressed;
    logic press;
    logic rel;
    logic long_press;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    logic [3:0] sb[$];

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_ni      (btn_n),
        .pressed_o   (pressed),
        .press_o     (press),
        .release_o   (rel),
        .long_press_o(long_press)
    );

    always #25 clk = ~clk;

    // After posedge number e has settled, cyc == e.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the level flips once D consecutive delayed samples disagree with it;
    // the long pulse fires L edges after a press unless that edge accepts a release.
    initial begin : model
        bit level = 1'b0;
        bit d0 = 1'b1;
        bit d1 = 1'b1;
        int run = 0;
        int since = 0;
        bit held, was, pr, rl, lg;
        forever begin
            @(posedge clk);
            pr = 1'b0;
            rl = 1'b0;
            lg = 1'b0;
            if (!rst_n) begin
                level = 1'b0;
                run   = 0;
                since = 0;
                d0    = 1'b1;
                d1    = 1'b1;
            end else begin
                held = !d1;
                d1   = d0;
                d0   = btn_n;
                was  = level;
                if (held != level) run++;
                else run = 0;
                if (run == D) begin
                    level = held;
                    run   = 0;
                    if (held) begin
                        pr    = 1'b1;
                        since = 0;
                    end else begin
                        rl = 1'b1;
                    end
                end
                if (was && since < L) begin
                    since++;
                    lg = LongEn && (since == L) && !rl;
                end
            end
            sb.push_back({level, pr, rl, lg});
        end
    end

    initial begin : monitor
        logic [3:0] exp_v;
        logic [3:0] act_v;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {pressed, press, rel, long_press};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard edge %0d: {pressed,press,release,long} got %b expected %b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2ms;
        errors++;
        $display("FAIL watchdog: bench did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stimulus
        int c0;
        int p;
        int f;

        idle(3);
        chk("reset pressed", pressed, 1'b0);
        chk("reset press", press, 1'b0);
        chk("reset release", rel, 1'b0);
        chk("reset long", long_press, 1'b0);
        #1 rst_n = 1'b1;
        idle(3);

        // Clean press
        btn_n = 1'b0;
        c0 = cyc + 1;
        at_edge(c0 + 4);
        chk("t1 pressed early", pressed, 1'b0);
        chk("t1 press early", press, 1'b0);
        at_edge(c0 + 5);
        chk("t1 pressed", pressed, 1'b1);
        chk("t1 press", press, 1'b1);
        at_edge(c0 + 6);
        chk("t1 press falls", press, 1'b0);
        chk("t1 no release", rel, 1'b0);
        idle(4);
        btn_n = 1'b1;
        idle(10);

        // Bouncing press
        btn_n = 1'b0;
        idle(3);
        btn_n = 1'b1;
        idle(1);
        btn_n = 1'b0;
        c0 = cyc + 1;
        at_edge(c0 + 4);
        chk("t2 press early", press, 1'b0);
        at_edge(c0 + 5);
        chk("t2 press", press, 1'b1);
        idle(3);

        // Bouncing release
        btn_n = 1'b1;
        idle(2);
        btn_n = 1'b0;
        idle(1);
        btn_n = 1'b1;
        c0 = cyc + 1;
        at_edge(c0 + 4);
        chk("t3 pressed holds", pressed, 1'b1);
        chk("t3 release early", rel, 1'b0);
        at_edge(c0 + 5);
        chk("t3 release", rel, 1'b1);
        chk("t3 pressed falls", pressed, 1'b0);
        idle(3);

        // Long press
        btn_n = 1'b0;
        c0 = cyc + 1;
        p = c0 + 5;
        at_edge(p + 15);
        chk("t4 long early", long_press, 1'b0);
        at_edge(p + 16);
        chk("t4 long", long_press, LongEn);
        at_edge(p + 17);
        chk("t4 long falls", long_press, 1'b0);
        at_edge(p + 30);
        chk("t4 still pressed", pressed, 1'b1);
        chk("t4 no repeat", long_press, 1'b0);

        // Reset while pressed, button held through deassertion
        #1 rst_n = 1'b0;
        #1 chk("t5a pressed cleared", pressed, 1'b0);
        idle(2);
        #1 rst_n = 1'b1;
        f = cyc + 1;
        at_edge(f + 4);
        chk("t5a press early", press, 1'b0);
        at_edge(f + 5);
        chk("t5a fresh press", press, 1'b1);
        btn_n = 1'b1;
        idle(12);

        // Reset mid-pending
        btn_n = 1'b0;
        c0 = cyc + 1;
        at_edge(c0 + 4);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 pressed", pressed, 1'b0);
        chk("t5 press", press, 1'b0);
        chk("t5 release", rel, 1'b0);
        chk("t5 long", long_press, 1'b0);
        idle(2);
        #1 rst_n = 1'b1;
        f = cyc + 1;
        at_edge(f + 4);
        chk("t5 press early", press, 1'b0);
        at_edge(f + 5);
        chk("t5 press after reset", press, 1'b1);
        btn_n = 1'b1;
        idle(12);

        // Release accepted on the saturating edge
        btn_n = 1'b0;
        c0 = cyc + 1;
        p = c0 + 5;
        at_edge(p + 10);
        btn_n = 1'b1;
        at_edge(p + 16);
        chk("t6 release", rel, 1'b1);
        chk("t6 long suppressed", long_press, 1'b0);
        chk("t6 pressed falls", pressed, 1'b0);
        at_edge(p + 17);
        chk("t6 no late long", long_press, 1'b0);
        idle(5);

        // Random runs with occasional resets
        for (int i = 0; i < 60; i++) begin
            btn_n = 1'($urandom_range(0, 1));
            idle(int'($urandom_range(1, 24)));
            if ($urandom_range(0, 11) == 0) begin
                #1 rst_n = 1'b0;
                idle(int'($urandom_range(1, 2)));
                #1 rst_n = 1'b1;
            end
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
